// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: PC sequencer state encoding and default vectors.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DELAY = 2'd1,
    HALT  = 2'd2
  } pc_seq_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'hBFC0_0380;
  localparam int          DEFAULT_PC_INC       = 4;

endpackage

// File: rtl/mips_cpu_pc_seq.sv
// PC sequencer with one branch delay slot and a halt-on-jump-to-HALT_ADDR state.
// Optional exception entry is enabled by defining MIPS_CPU_PC_SEQ_EXC_EN.
module mips_cpu_pc_seq
  import mips_cpu_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEFAULT_HALT_ADDR),
  parameter int                PC_INC       = DEFAULT_PC_INC
`ifdef MIPS_CPU_PC_SEQ_EXC_EN
  ,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
`ifdef MIPS_CPU_PC_SEQ_EXC_EN
  input  logic              exc_req,
`endif
  output logic [ADDR_W-1:0] pc_out,
  output logic              active,
  output logic              delay_slot
);

  pc_seq_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] target_reg, target_next;
  logic              delay_slot_reg, delay_slot_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RUN;
      pc_reg         <= RESET_VECTOR;
      target_reg     <= '0;
      delay_slot_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      target_reg     <= target_next;
      delay_slot_reg <= delay_slot_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    target_next     = target_reg;
    delay_slot_next = delay_slot_reg;

    case (state_reg)
      RUN: begin
        if (!stall) begin
          pc_next         = pc_reg + ADDR_W'(PC_INC);
          delay_slot_next = 1'b0;
          if (redirect_valid) begin
            target_next     = redirect_target;
            state_next      = DELAY;
            delay_slot_next = 1'b1;
          end
        end
      end
      DELAY: begin
        // A redirect seen here would be a branch in a delay slot; it is dropped.
        if (!stall) begin
          pc_next         = target_reg;
          delay_slot_next = 1'b0;
          state_next      = (target_reg == HALT_ADDR) ? HALT : RUN;
        end
      end
      HALT: begin
        pc_next         = HALT_ADDR;
        delay_slot_next = 1'b0;
      end
      default: begin
        state_next      = RUN;
        pc_next         = RESET_VECTOR;
        target_next     = '0;
        delay_slot_next = 1'b0;
      end
    endcase

`ifdef MIPS_CPU_PC_SEQ_EXC_EN
    // Exceptions override stall and any pending delay-slot redirect.
    if (exc_req && (state_reg != HALT)) begin
      state_next      = RUN;
      pc_next         = EXC_VECTOR;
      target_next     = '0;
      delay_slot_next = 1'b0;
    end
`endif
  end

  assign pc_out     = pc_reg;
  assign delay_slot = delay_slot_reg;
  assign active     = (state_reg != HALT);

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// Directed self-checking bench for mips_cpu_pc_seq (exception path under MIPS_CPU_PC_SEQ_EXC_EN).
module tb_mips_cpu_pc_seq;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef MIPS_CPU_PC_SEQ_EXC_EN
  logic        exc_req;
`endif
  logic [31:0] pc_out;
  logic        active;
  logic        delay_slot;

  int checks = 0;
  int errors = 0;

  mips_cpu_pc_seq dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
`ifdef MIPS_CPU_PC_SEQ_EXC_EN
    .exc_req         (exc_req),
`endif
    .pc_out          (pc_out),
    .active          (active),
    .delay_slot      (delay_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic act, input logic ds);
    check({tag, "_pc"}, pc_out, pc);
    check({tag, "_active"}, {31'd0, active}, {31'd0, act});
    check({tag, "_ds"}, {31'd0, delay_slot}, {31'd0, ds});
    $display("%0t %s pc=%08h active=%0b ds=%0b", $time, tag, pc_out, active, delay_slot);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
`ifdef MIPS_CPU_PC_SEQ_EXC_EN
    exc_req = 1'b0;
`endif
    #3;
    expect_out("reset", 32'hBFC0_0000, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch after reset
    step(); expect_out("seq1", 32'hBFC0_0004, 1'b1, 1'b0);
    step(); expect_out("seq2", 32'hBFC0_0008, 1'b1, 1'b0);
    step(); expect_out("seq3", 32'hBFC0_000C, 1'b1, 1'b0);
    step(); expect_out("seq4", 32'hBFC0_0010, 1'b1, 1'b0);

    // Basic branch with delay slot
    redirect_valid = 1'b1; redirect_target = 32'h8000_0020;
    step(); expect_out("br_slot", 32'hBFC0_0014, 1'b1, 1'b1);
    redirect_valid = 1'b0;
    step(); expect_out("br_tgt", 32'h8000_0020, 1'b1, 1'b0);

    // Unaligned target; stall in DELAY; redirects in DELAY ignored
    redirect_valid = 1'b1; redirect_target = 32'h1234_5677;
    step(); expect_out("ua_slot", 32'h8000_0024, 1'b1, 1'b1);
    stall = 1'b1; redirect_target = 32'hAAAA_0000;
    step(); expect_out("dstall1", 32'h8000_0024, 1'b1, 1'b1);
    step(); expect_out("dstall2", 32'h8000_0024, 1'b1, 1'b1);
    step(); expect_out("dstall3", 32'h8000_0024, 1'b1, 1'b1);
    stall = 1'b0;
    step(); expect_out("ua_tgt", 32'h1234_5677, 1'b1, 1'b0);
    redirect_valid = 1'b0;

    // Stall in RUN
    stall = 1'b1;
    step(); expect_out("rstall", 32'h1234_5677, 1'b1, 1'b0);
    stall = 1'b0;
    step(); expect_out("rstall_rel", 32'h1234_567B, 1'b1, 1'b0);

    // Wrap-around to zero does not halt
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    step(); expect_out("wr_slot", 32'h1234_567F, 1'b1, 1'b1);
    redirect_valid = 1'b0;
    step(); expect_out("wr_tgt", 32'hFFFF_FFF8, 1'b1, 1'b0);
    step(); expect_out("wr_fc", 32'hFFFF_FFFC, 1'b1, 1'b0);
    step(); expect_out("wr_zero", 32'h0000_0000, 1'b1, 1'b0);
    step(); expect_out("wr_four", 32'h0000_0004, 1'b1, 1'b0);

    // Asynchronous reset in DELAY discards pending target
    redirect_valid = 1'b1; redirect_target = 32'h4000_0000;
    step(); expect_out("ar_slot", 32'h0000_0008, 1'b1, 1'b1);
    redirect_valid = 1'b0;
    #1 rst = 1'b1;
    #1 expect_out("ar_async", 32'hBFC0_0000, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(); expect_out("ar_rel1", 32'hBFC0_0004, 1'b1, 1'b0);
    step(); expect_out("ar_rel2", 32'hBFC0_0008, 1'b1, 1'b0);

`ifdef MIPS_CPU_PC_SEQ_EXC_EN
    // Exception in stalled DELAY drops the pending target
    redirect_valid = 1'b1; redirect_target = 32'h5000_0000;
    step(); expect_out("ex_slot", 32'hBFC0_000C, 1'b1, 1'b1);
    redirect_valid = 1'b0; stall = 1'b1; exc_req = 1'b1;
    step(); expect_out("ex_entry", 32'hBFC0_0380, 1'b1, 1'b0);
    stall = 1'b0; exc_req = 1'b0;
    step(); expect_out("ex_next", 32'hBFC0_0384, 1'b1, 1'b0);
`endif

    // Jump to HALT_ADDR: delay slot then terminal halt
    redirect_valid = 1'b1; redirect_target = 32'h0000_0000;
    step();
`ifdef MIPS_CPU_PC_SEQ_EXC_EN
    expect_out("h_slot", 32'hBFC0_0388, 1'b1, 1'b1);
`else
    expect_out("h_slot", 32'hBFC0_000C, 1'b1, 1'b1);
`endif
    redirect_valid = 1'b0;
    step(); expect_out("h_enter", 32'h0000_0000, 1'b0, 1'b0);
    redirect_valid = 1'b1; redirect_target = 32'h1111_1110;
    step(); expect_out("h_redir1", 32'h0000_0000, 1'b0, 1'b0);
    step(); expect_out("h_redir2", 32'h0000_0000, 1'b0, 1'b0);
    redirect_valid = 1'b0; stall = 1'b1;
`ifdef MIPS_CPU_PC_SEQ_EXC_EN
    exc_req = 1'b1;
`endif
    step(); expect_out("h_stall", 32'h0000_0000, 1'b0, 1'b0);
    stall = 1'b0;
    step(); expect_out("h_idle", 32'h0000_0000, 1'b0, 1'b0);
`ifdef MIPS_CPU_PC_SEQ_EXC_EN
    exc_req = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
